// File: rtl/board_mem_scheduler.sv
// Shares the single-port board RAM between the per-scanline row prefetch into the
// renderer's line buffer (priority) and game-logic accesses granted only while idle.
module board_mem_scheduler #(
  parameter int unsigned BoardCols = 10,
  parameter int unsigned BoardRows = 20,
  parameter int unsigned BoardY0   = 80,
  parameter int unsigned CellLog2  = 4,
  parameter int unsigned ColorW    = 3,
  parameter int unsigned AddrW     = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              line_start_i,
  input  logic [9:0]        line_y_i,
  input  logic              game_req_i,
  input  logic              game_we_i,
  input  logic [AddrW-1:0]  game_addr_i,
  input  logic [ColorW-1:0] game_wdata_i,
  output logic              game_gnt_o,
  output logic              game_rvalid_o,
  output logic [ColorW-1:0] game_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [AddrW-1:0]  mem_addr_o,
  output logic [ColorW-1:0] mem_wdata_o,
  input  logic [ColorW-1:0] mem_rdata_i,
  output logic              lb_we_o,
  output logic [3:0]        lb_idx_o,
  output logic [ColorW-1:0] lb_data_o,
  output logic              lb_row_valid_o,
  output logic              fetch_busy_o,
  output logic              overrun_o
);

  typedef enum logic {StIdle, StFetch} state_e;

  localparam logic [9:0]       YStart   = 10'(BoardY0);
  localparam logic [10:0]      YEnd     = 11'(BoardY0 + (BoardRows << CellLog2));
  localparam logic [AddrW-1:0] NumCells = AddrW'(BoardCols * BoardRows);
  localparam logic [3:0]       LastCol  = 4'(BoardCols - 1);

  state_e           state_q, state_d;
  logic [3:0]       col_q, col_d;
  logic [AddrW-1:0] row_q, row_d;
  logic             lb_valid_q, lb_valid_d;
  logic             overrun_q, overrun_d;
  logic             lb_we_q, lb_we_d;
  logic [3:0]       lb_idx_q, lb_idx_d;
  logic             rvalid_q, rvalid_d;
  logic             oob_q, oob_d;

  logic [9:0]       y_off;
  logic             y_in_board;
  logic             game_in_range;
  logic [AddrW-1:0] fetch_addr;

  assign y_off         = line_y_i - YStart;
  assign y_in_board    = (line_y_i >= YStart) && ({1'b0, line_y_i} < YEnd);
  assign game_in_range = game_addr_i < NumCells;
  // row*10 + col without a multiplier
  assign fetch_addr    = (row_q << 3) + (row_q << 1) + AddrW'(col_q);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    lb_valid_d  = lb_valid_q;
    overrun_d   = 1'b0;
    lb_we_d     = 1'b0;
    lb_idx_d    = '0;
    rvalid_d    = 1'b0;
    oob_d       = 1'b0;
    game_gnt_o  = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    if (lb_we_q && (lb_idx_q == LastCol)) begin
      lb_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (game_req_i) begin
          game_gnt_o  = 1'b1;
          // Out-of-range accesses are acknowledged but never reach the RAM
          mem_en_o    = game_in_range;
          mem_we_o    = game_we_i & game_in_range;
          mem_addr_o  = game_addr_i;
          mem_wdata_o = game_wdata_i;
          rvalid_d    = ~game_we_i;
          oob_d       = ~game_in_range;
        end
        if (line_start_i) begin
          lb_valid_d = 1'b0;
          if (y_in_board) begin
            row_d   = AddrW'(y_off >> CellLog2);
            col_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        mem_en_o   = 1'b1;
        mem_addr_o = fetch_addr;
        lb_we_d    = 1'b1;
        lb_idx_d   = col_q;
        col_d      = col_q + 4'd1;
        overrun_d  = line_start_i;
        if (col_q == LastCol) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      lb_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      lb_we_q    <= 1'b0;
      lb_idx_q   <= '0;
      rvalid_q   <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      lb_valid_q <= lb_valid_d;
      overrun_q  <= overrun_d;
      lb_we_q    <= lb_we_d;
      lb_idx_q   <= lb_idx_d;
      rvalid_q   <= rvalid_d;
      oob_q      <= oob_d;
    end
  end

  assign game_rvalid_o  = rvalid_q;
  assign game_rdata_o   = (rvalid_q && !oob_q) ? mem_rdata_i : '0;
  assign lb_we_o        = lb_we_q;
  assign lb_idx_o       = lb_idx_q;
  assign lb_data_o      = lb_we_q ? mem_rdata_i : '0;
  assign lb_row_valid_o = lb_valid_q;
  assign fetch_busy_o   = (state_q == StFetch);
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_board_mem_scheduler.sv
// Directed bench for board_mem_scheduler with a behavioural sync board RAM.
module tb_board_mem_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       line_start_i;
  logic [9:0] line_y_i;
  logic       game_req_i;
  logic       game_we_i;
  logic [7:0] game_addr_i;
  logic [2:0] game_wdata_i;
  logic       game_gnt_o;
  logic       game_rvalid_o;
  logic [2:0] game_rdata_o;
  logic       mem_en_o;
  logic       mem_we_o;
  logic [7:0] mem_addr_o;
  logic [2:0] mem_wdata_o;
  logic [2:0] mem_rdata_i;
  logic       lb_we_o;
  logic [3:0] lb_idx_o;
  logic [2:0] lb_data_o;
  logic       lb_row_valid_o;
  logic       fetch_busy_o;
  logic       overrun_o;

  int total = 0;
  int bad   = 0;

  logic [2:0] ram [256];

  always #5 clk_i = ~clk_i;

  board_mem_scheduler dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .line_start_i   (line_start_i),
    .line_y_i       (line_y_i),
    .game_req_i     (game_req_i),
    .game_we_i      (game_we_i),
    .game_addr_i    (game_addr_i),
    .game_wdata_i   (game_wdata_i),
    .game_gnt_o     (game_gnt_o),
    .game_rvalid_o  (game_rvalid_o),
    .game_rdata_o   (game_rdata_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .lb_we_o        (lb_we_o),
    .lb_idx_o       (lb_idx_o),
    .lb_data_o      (lb_data_o),
    .lb_row_valid_o (lb_row_valid_o),
    .fetch_busy_o   (fetch_busy_o),
    .overrun_o      (overrun_o)
  );

  // Sync single-port RAM, 1-cycle read latency
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i     <= ram[mem_addr_o];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_line(input logic [9:0] y);
    step();
    line_start_i = 1'b1;
    line_y_i     = y;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " mem_en"},   32'(mem_en_o), 0);
    check_eq({tag, " fetch"},    32'(fetch_busy_o), 0);
    check_eq({tag, " lb_we"},    32'(lb_we_o), 0);
    check_eq({tag, " lb_idx"},   32'(lb_idx_o), 0);
    check_eq({tag, " lb_valid"}, 32'(lb_row_valid_o), 0);
    check_eq({tag, " overrun"},  32'(overrun_o), 0);
    check_eq({tag, " rvalid"},   32'(game_rvalid_o), 0);
    check_eq({tag, " rdata"},    32'(game_rdata_o), 0);
    check_eq({tag, " gnt"},      32'(game_gnt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 3'(k % 8);
    mem_rdata_i  = '0;
    rst_ni       = 1'b0;
    line_start_i = 1'b0;
    line_y_i     = '0;
    game_req_i   = 1'b0;
    game_we_i    = 1'b0;
    game_addr_i  = '0;
    game_wdata_i = '0;
    step();
    step();
    check_all_zero("reset");
    rst_ni = 1'b1;

    // 1: reset mid-burst
    start_line(10'd80);
    for (int c = 1; c <= 5; c++) begin
      step();
      line_start_i = 1'b0;
    end
    #1;
    check_eq("t1 busy before rst", 32'(fetch_busy_o), 1);
    rst_ni = 1'b0;
    step();
    check_all_zero("t1 rst");
    rst_ni = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check_eq($sformatf("t1 lb_we c%0d", c), 32'(lb_we_o), 0);
      check_eq($sformatf("t1 mem_en c%0d", c), 32'(mem_en_o), 0);
    end
    check_eq("t1 lb_valid", 32'(lb_row_valid_o), 0);

    // 2: full fetch of row 0
    start_line(10'd80);
    for (int c = 1; c <= 12; c++) begin
      step();
      line_start_i = 1'b0;
      #1;
      check_eq($sformatf("t2 mem_en c%0d", c), 32'(mem_en_o), (c <= 10) ? 1 : 0);
      if (c <= 10) begin
        check_eq($sformatf("t2 addr c%0d", c), 32'(mem_addr_o), 32'(c - 1));
        check_eq($sformatf("t2 mem_we c%0d", c), 32'(mem_we_o), 0);
      end
      check_eq($sformatf("t2 lb_we c%0d", c), 32'(lb_we_o), (c >= 2 && c <= 11) ? 1 : 0);
      if (c >= 2 && c <= 11) begin
        check_eq($sformatf("t2 lb_idx c%0d", c), 32'(lb_idx_o), 32'(c - 2));
        check_eq($sformatf("t2 lb_data c%0d", c), 32'(lb_data_o), 32'((c - 2) % 8));
      end
      check_eq($sformatf("t2 lb_valid c%0d", c), 32'(lb_row_valid_o), (c == 12) ? 1 : 0);
      check_eq($sformatf("t2 busy c%0d", c), 32'(fetch_busy_o), (c <= 10) ? 1 : 0);
    end

    // 3: last row and both out-of-board lines
    start_line(10'd399);
    for (int c = 1; c <= 12; c++) begin
      step();
      line_start_i = 1'b0;
      #1;
      if (c <= 10) check_eq($sformatf("t3 addr c%0d", c), 32'(mem_addr_o), 32'(189 + c));
      if (c == 12) check_eq("t3 lb_valid", 32'(lb_row_valid_o), 1);
    end
    for (int n = 0; n < 2; n++) begin
      start_line((n == 0) ? 10'd400 : 10'd79);
      #1;
      check_eq($sformatf("t3 y%0d mem_en T", n), 32'(mem_en_o), 0);
      for (int c = 1; c <= 12; c++) begin
        step();
        line_start_i = 1'b0;
        #1;
        check_eq($sformatf("t3 y%0d mem_en c%0d", n, c), 32'(mem_en_o), 0);
        check_eq($sformatf("t3 y%0d valid c%0d", n, c), 32'(lb_row_valid_o), 0);
      end
    end

    // 4: game write held during a fetch
    start_line(10'd80);
    for (int c = 1; c <= 11; c++) begin
      step();
      line_start_i = 1'b0;
      game_req_i   = 1'b1;
      game_we_i    = 1'b1;
      game_addr_i  = 8'd5;
      game_wdata_i = 3'd6;
      #1;
      check_eq($sformatf("t4 gnt c%0d", c), 32'(game_gnt_o), (c == 11) ? 1 : 0);
    end
    check_eq("t4 mem_en", 32'(mem_en_o), 1);
    check_eq("t4 mem_we", 32'(mem_we_o), 1);
    check_eq("t4 mem_addr", 32'(mem_addr_o), 5);
    check_eq("t4 mem_wdata", 32'(mem_wdata_o), 6);
    step();
    game_req_i = 1'b0;
    #1;
    check_eq("t4 ram5", 32'(ram[5]), 6);

    // 5: idle write/read of cell 37, then out-of-range accesses
    step();
    game_req_i = 1'b1; game_we_i = 1'b1; game_addr_i = 8'd37; game_wdata_i = 3'd3;
    #1;
    check_eq("t5 wr gnt", 32'(game_gnt_o), 1);
    step();
    game_we_i = 1'b0;
    #1;
    check_eq("t5 rd gnt", 32'(game_gnt_o), 1);
    check_eq("t5 rd mem_en", 32'(mem_en_o), 1);
    check_eq("t5 rd mem_we", 32'(mem_we_o), 0);
    check_eq("t5 rd addr", 32'(mem_addr_o), 37);
    check_eq("t5 rd rvalid same", 32'(game_rvalid_o), 0);
    step();
    game_req_i = 1'b0;
    #1;
    check_eq("t5 rvalid", 32'(game_rvalid_o), 1);
    check_eq("t5 rdata", 32'(game_rdata_o), 3);
    step();
    game_req_i = 1'b1; game_we_i = 1'b1; game_addr_i = 8'd210; game_wdata_i = 3'd5;
    #1;
    check_eq("t5 oob wr gnt", 32'(game_gnt_o), 1);
    check_eq("t5 oob wr mem_en", 32'(mem_en_o), 0);
    check_eq("t5 rvalid idle", 32'(game_rvalid_o), 0);
    check_eq("t5 rdata idle", 32'(game_rdata_o), 0);
    step();
    game_we_i = 1'b0;
    #1;
    check_eq("t5 oob rd gnt", 32'(game_gnt_o), 1);
    check_eq("t5 oob rd mem_en", 32'(mem_en_o), 0);
    step();
    game_req_i = 1'b0;
    #1;
    check_eq("t5 oob rvalid", 32'(game_rvalid_o), 1);
    check_eq("t5 oob rdata", 32'(game_rdata_o), 0);

    // 6: second line_start during a fetch
    start_line(10'd96);
    for (int c = 1; c <= 12; c++) begin
      step();
      line_start_i = (c == 4);
      line_y_i     = (c == 4) ? 10'd80 : 10'd96;
      #1;
      check_eq($sformatf("t6 overrun c%0d", c), 32'(overrun_o), (c == 5) ? 1 : 0);
      check_eq($sformatf("t6 busy c%0d", c), 32'(fetch_busy_o), (c <= 10) ? 1 : 0);
      if (c <= 10) check_eq($sformatf("t6 addr c%0d", c), 32'(mem_addr_o), 32'(9 + c));
      check_eq($sformatf("t6 lb_valid c%0d", c), 32'(lb_row_valid_o), (c == 12) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
